// File: rtl/pong_pkg.sv
// Shared playfield geometry, FSM encoding and small arithmetic helpers for the
// pong game controller and the VGA renderer.
package pong_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BALL_W    = 8;
  localparam int PADDLE_W  = 8;
  localparam int PADDLE_H  = 80;
  localparam int PADDLE1_X = 16;
  localparam int PADDLE2_X = 608;

  // Signed 12-bit forms used by the position datapath; wide enough to never wrap.
  localparam logic signed [11:0] BALL_W_S     = 12'sd8;
  localparam logic signed [11:0] PADDLE_H_S   = 12'sd80;
  localparam logic signed [11:0] PADDLE1_X_S  = 12'sd16;
  localparam logic signed [11:0] PADDLE2_X_S  = 12'sd608;
  localparam logic signed [11:0] P1_HIT_X     = 12'sd24;
  localparam logic signed [11:0] P2_HIT_X     = 12'sd600;
  localparam logic signed [11:0] P1_REACH_X   = 12'sd24;
  localparam logic signed [11:0] P2_REACH_X   = 12'sd616;
  localparam logic signed [11:0] BALL_X_MAX   = 12'sd632;
  localparam logic signed [11:0] BALL_Y_MAX   = 12'sd472;
  localparam logic signed [11:0] PADDLE_Y_MAX = 12'sd400;
  localparam logic signed [11:0] BALL_X0      = 12'sd316;
  localparam logic signed [11:0] BALL_Y0      = 12'sd236;
  localparam logic signed [11:0] PADDLE_Y0    = 12'sd200;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SERVE  = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_POINT  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
    logic               dx_pos;
    logic               dy_pos;
    logic               goal_p1;
    logic               goal_p2;
  } ball_step_t;

  function automatic logic signed [11:0] paddle_next(input logic signed [11:0] y,
                                                     input logic up, input logic dn,
                                                     input logic signed [11:0] spd);
    logic signed [11:0] t;
    if (up && !dn) begin
      t = y - spd;
      t = (t < 12'sd0) ? 12'sd0 : t;
    end else if (dn && !up) begin
      t = y + spd;
      t = (t > PADDLE_Y_MAX) ? PADDLE_Y_MAX : t;
    end else begin
      t = y;
    end
    return t;
  endfunction

  function automatic logic [3:0] score_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? lim : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Player/renderer-facing signal bundle of the pong game controller.
interface pong_game_ctrl_if;
  logic               i_frame_tick;
  logic               i_start;
  logic               i_p1_up;
  logic               i_p1_down;
  logic               i_p2_up;
  logic               i_p2_down;
  logic signed [10:0] o_ball_x;
  logic signed [10:0] o_ball_y;
  logic signed [10:0] o_paddle1_y;
  logic signed [10:0] o_paddle2_y;
  logic               o_finish;
  logic [3:0]         o_score1;
  logic [3:0]         o_score2;

  modport master (
    output i_frame_tick, i_start, i_p1_up, i_p1_down, i_p2_up, i_p2_down,
    input  o_ball_x, o_ball_y, o_paddle1_y, o_paddle2_y, o_finish, o_score1, o_score2
  );

  modport slave (
    input  i_frame_tick, i_start, i_p1_up, i_p1_down, i_p2_up, i_p2_down,
    output o_ball_x, o_ball_y, o_paddle1_y, o_paddle2_y, o_finish, o_score1, o_score2
  );
endinterface

// File: rtl/pong_ball_step.sv
// One-frame ball advance: walls, paddle bounces and goal detection.
module pong_ball_step
  import pong_pkg::*;
#(
  parameter int BALL_SPEED = 2
) (
  input  logic signed [11:0] x_i,
  input  logic signed [11:0] y_i,
  input  logic               dx_pos_i,
  input  logic               dy_pos_i,
  input  logic signed [11:0] pad1_i,
  input  logic signed [11:0] pad2_i,
  output ball_step_t         step_o
);

  localparam logic signed [11:0] SPD = 12'(BALL_SPEED);

  logic signed [11:0] nx_s;
  logic signed [11:0] ny_s;
  logic               ov1_s;
  logic               ov2_s;

  // Overlap uses the ball row and paddle rows from before this frame.
  always_comb begin
    nx_s   = dx_pos_i ? (x_i + SPD) : (x_i - SPD);
    ny_s   = dy_pos_i ? (y_i + SPD) : (y_i - SPD);
    ov1_s  = (y_i + BALL_W_S > pad1_i) && (y_i < pad1_i + PADDLE_H_S);
    ov2_s  = (y_i + BALL_W_S > pad2_i) && (y_i < pad2_i + PADDLE_H_S);
    step_o = '{x: nx_s, y: ny_s, dx_pos: dx_pos_i, dy_pos: dy_pos_i,
               goal_p1: 1'b0, goal_p2: 1'b0};
    // A goal leaves the raw candidate position in place, with no wall correction.
    if (nx_s < 12'sd0) begin
      step_o.goal_p2 = 1'b1;
    end else if (nx_s > BALL_X_MAX) begin
      step_o.goal_p1 = 1'b1;
    end else begin
      if (ny_s <= 12'sd0) begin
        step_o.y      = 12'sd0;
        step_o.dy_pos = 1'b1;
      end else if (ny_s >= BALL_Y_MAX) begin
        step_o.y      = BALL_Y_MAX;
        step_o.dy_pos = 1'b0;
      end else begin
        step_o.y = ny_s;
      end
      if (!dx_pos_i && (nx_s + BALL_W_S >= PADDLE1_X_S) && (nx_s <= P1_REACH_X) && ov1_s) begin
        step_o.x      = P1_HIT_X;
        step_o.dx_pos = 1'b1;
      end else if (dx_pos_i && (nx_s + BALL_W_S >= PADDLE2_X_S) && (nx_s <= P2_REACH_X) && ov2_s) begin
        step_o.x      = P2_HIT_X;
        step_o.dx_pos = 1'b0;
      end else begin
        step_o.x = nx_s;
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: frame/start edge detection, paddle motion, scoring and
// the IDLE/SERVE/PLAY/POINT/FINISH flow.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  pong_game_ctrl_if.slave  bus
);

  localparam logic [3:0]         WIN      = 4'(WIN_SCORE);
  localparam logic [7:0]         SERVE_LST = 8'(SERVE_FRAMES - 1);
  localparam logic signed [11:0] PSPD     = 12'(PADDLE_SPEED);

  logic [2:0]         state_q, state_d;
  logic               frame_q, start_q;
  logic signed [11:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic signed [11:0] pad1_q, pad1_d, pad2_q, pad2_d;
  logic               dx_q, dx_d, dy_q, dy_d;
  logic [3:0]         score1_q, score1_d, score2_q, score2_d;
  logic               finish_q, finish_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               p1_scored_q, p1_scored_d;
  logic               frame_evt_s, start_evt_s;
  logic [3:0]         new_score_s;
  ball_step_t         step_s;

  assign frame_evt_s = bus.i_frame_tick & ~frame_q;
  assign start_evt_s = bus.i_start & ~start_q;

  pong_ball_step #(.BALL_SPEED(BALL_SPEED)) u_step (
    .x_i      (ball_x_q),
    .y_i      (ball_y_q),
    .dx_pos_i (dx_q),
    .dy_pos_i (dy_q),
    .pad1_i   (pad1_q),
    .pad2_i   (pad2_q),
    .step_o   (step_s)
  );

  // Match FSM and next-state datapath.
  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    pad1_d      = pad1_q;
    pad2_d      = pad2_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    finish_d    = finish_q;
    cnt_d       = cnt_q;
    p1_scored_d = p1_scored_q;
    new_score_s = p1_scored_q ? score_inc(score1_q, WIN) : score_inc(score2_q, WIN);
    case (state_q)
      ST_IDLE: begin
        if (start_evt_s) begin
          state_d  = ST_SERVE;
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
          cnt_d    = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (frame_evt_s) begin
          pad1_d = paddle_next(pad1_q, bus.i_p1_up, bus.i_p1_down, PSPD);
          pad2_d = paddle_next(pad2_q, bus.i_p2_up, bus.i_p2_down, PSPD);
          if (cnt_q == SERVE_LST) begin
            state_d = ST_PLAY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_PLAY: begin
        if (frame_evt_s) begin
          pad1_d   = paddle_next(pad1_q, bus.i_p1_up, bus.i_p1_down, PSPD);
          pad2_d   = paddle_next(pad2_q, bus.i_p2_up, bus.i_p2_down, PSPD);
          ball_x_d = step_s.x;
          ball_y_d = step_s.y;
          dx_d     = step_s.dx_pos;
          dy_d     = step_s.dy_pos;
          if (step_s.goal_p1 || step_s.goal_p2) begin
            state_d     = ST_POINT;
            p1_scored_d = step_s.goal_p1;
          end else begin
            state_d = ST_PLAY;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_POINT: begin
        if (p1_scored_q) begin
          score1_d = new_score_s;
        end else begin
          score2_d = new_score_s;
        end
        if (new_score_s == WIN) begin
          state_d  = ST_FINISH;
          finish_d = 1'b1;
        end else begin
          // Serve toward the player who just conceded.
          state_d  = ST_SERVE;
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
          dx_d     = p1_scored_q;
          cnt_d    = 8'd0;
        end
      end
      ST_FINISH: begin
        if (start_evt_s) begin
          state_d  = ST_SERVE;
          ball_x_d = BALL_X0;
          ball_y_d = BALL_Y0;
          pad1_d   = PADDLE_Y0;
          pad2_d   = PADDLE_Y0;
          dx_d     = 1'b1;
          dy_d     = 1'b1;
          score1_d = 4'd0;
          score2_d = 4'd0;
          finish_d = 1'b0;
          cnt_d    = 8'd0;
        end else begin
          state_d = ST_FINISH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; every output is driven straight from one of these.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      frame_q     <= 1'b0;
      start_q     <= 1'b0;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      pad1_q      <= PADDLE_Y0;
      pad2_q      <= PADDLE_Y0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      finish_q    <= 1'b0;
      cnt_q       <= 8'd0;
      p1_scored_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= bus.i_frame_tick;
      start_q     <= bus.i_start;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      pad1_q      <= pad1_d;
      pad2_q      <= pad2_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      finish_q    <= finish_d;
      cnt_q       <= cnt_d;
      p1_scored_q <= p1_scored_d;
    end
  end

  assign bus.o_ball_x    = ball_x_q[10:0];
  assign bus.o_ball_y    = ball_y_q[10:0];
  assign bus.o_paddle1_y = pad1_q[10:0];
  assign bus.o_paddle2_y = pad2_q[10:0];
  assign bus.o_finish    = finish_q;
  assign bus.o_score1    = score1_q;
  assign bus.o_score2    = score2_q;

endmodule
